// File: rtl/ladder_swap_ctrl_pkg.sv
// Shared state encoding and constants for the X25519 ladder swap initiator.
package ladder_swap_ctrl_pkg;

    localparam int WID_DEF   = 256;
    localparam int NBIT_DEF  = 255;
    localparam int IDXW_DEF  = 8;
    localparam int CSWAP_LAT = 3;

    // RFC 7748 clamp: clear bits 0..2 and 255, set bit 254
    localparam logic [255:0] CLAMP_AND = {1'b0, {252{1'b1}}, 3'b000};
    localparam logic [255:0] CLAMP_OR  = {2'b01, 254'd0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWAP_REQ,
        S_SWAP_WAIT,
        S_STEP,
        S_FINAL_REQ,
        S_FINAL_WAIT,
        S_DONE
    } state_e;

endpackage

// File: rtl/ladder_swap_ctrl.sv
// Constant-time cswap initiator for the X25519 Montgomery ladder.
// Define X25519_CLAMP_EN to clamp the scalar as it is latched.
module ladder_swap_ctrl
    import ladder_swap_ctrl_pkg::*;
#(
    parameter int WID  = WID_DEF,
    parameter int NBIT = NBIT_DEF,
    parameter int IDXW = IDXW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [WID-1:0]  scalar,
    output logic            busy,
    output logic            done,
    output logic [IDXW-1:0] bit_idx,
    output logic            cs_swap,
    output logic            cs_en,
    input  logic            cs_vld,
    output logic            step_req,
    input  logic            step_done
);

    state_e          state_q, state_d;
    logic [WID-1:0]  k_q, k_d, k_in;
    logic [IDXW-1:0] idx_q, idx_d, idx_nxt;
    logic            prev_q, prev_d;
    logic            cs_swap_q, cs_swap_d;
    logic            cs_en_q, cs_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            step_req_q, step_req_d;

`ifdef X25519_CLAMP_EN
    assign k_in = (scalar & CLAMP_AND[WID-1:0]) | CLAMP_OR[WID-1:0];
`else
    assign k_in = scalar;
`endif

    assign idx_nxt = idx_q - IDXW'(1);

    // Swap bit and prev are loaded on entry to a REQ state so cs_swap
    // is already valid in the cycle cs_en is high.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        idx_d      = idx_q;
        prev_d     = prev_q;
        cs_swap_d  = cs_swap_q;
        cs_en_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        step_req_d = step_req_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d       = k_in;
                    idx_d     = IDXW'(NBIT - 1);
                    prev_d    = k_in[NBIT-1];
                    cs_swap_d = k_in[NBIT-1];
                    cs_en_d   = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = S_SWAP_REQ;
                end
            end
            S_SWAP_REQ: state_d = S_SWAP_WAIT;
            S_SWAP_WAIT: begin
                if (cs_vld) begin
                    step_req_d = 1'b1;
                    state_d    = S_STEP;
                end
            end
            S_STEP: begin
                if (step_done) begin
                    step_req_d = 1'b0;
                    cs_en_d    = 1'b1;
                    if (idx_q == '0) begin
                        cs_swap_d = prev_q;
                        state_d   = S_FINAL_REQ;
                    end else begin
                        idx_d     = idx_nxt;
                        prev_d    = k_q[idx_nxt];
                        cs_swap_d = k_q[idx_nxt] ^ prev_q;
                        state_d   = S_SWAP_REQ;
                    end
                end
            end
            S_FINAL_REQ: state_d = S_FINAL_WAIT;
            S_FINAL_WAIT: begin
                if (cs_vld) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            idx_q      <= '0;
            prev_q     <= 1'b0;
            cs_swap_q  <= 1'b0;
            cs_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            step_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            idx_q      <= idx_d;
            prev_q     <= prev_d;
            cs_swap_q  <= cs_swap_d;
            cs_en_q    <= cs_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            step_req_q <= step_req_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bit_idx  = idx_q;
    assign cs_swap  = cs_swap_q;
    assign cs_en    = cs_en_q;
    assign step_req = step_req_q;

endmodule

// File: tb/tb_ladder_swap_ctrl.sv
// Bench for ladder_swap_ctrl: cswap/step responders, table vectors,
// corner sequences and random scalars against a bit-scan model.
`timescale 1ns/1ps
module tb_ladder_swap_ctrl;
    import ladder_swap_ctrl_pkg::*;

    localparam int W  = 256;
`ifdef X25519_CLAMP_EN
    localparam int NB = 255;
`else
    localparam int NB = 4;
`endif
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst, start, cs_vld, step_done;
    logic [W-1:0]  scalar;
    logic          busy, done, cs_swap, cs_en, step_req;
    logic [IW-1:0] bit_idx;

    ladder_swap_ctrl #(.WID(W), .NBIT(NB), .IDXW(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .scalar(scalar),
        .busy(busy), .done(done), .bit_idx(bit_idx),
        .cs_swap(cs_swap), .cs_en(cs_en), .cs_vld(cs_vld),
        .step_req(step_req), .step_done(step_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int step_lat  = 2;
    bit stray_vld = 1'b0;
    bit stray_sd  = 1'b0;

    bit sw_q[$];
    int idx_q[$];
    int done_tot = 0;
    int busy_tot = 0;
    int stab_tot = 0;

    bit exp_sw[$];
    int exp_idx[$];
    bit got_sw[$];
    int got_idx[$];
    int got_done, got_busy, got_stab;

    // cswap unit (fixed latency), step datapath, stray injection, monitor
    initial begin : resp
        int  vc, sc;
        bit  held, waiting;
        vc = 0; sc = 0; held = 1'b0; waiting = 1'b0;
        cs_vld = 1'b0; step_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            cs_vld = 1'b0; step_done = 1'b0;
            if (rst) begin
                vc = 0; sc = 0; waiting = 1'b0;
            end else begin
                if (vc > 0) begin vc--; cs_vld = (vc == 0); end
                if (cs_en) vc = CSWAP_LAT;
                if (sc > 0) begin
                    sc--; step_done = (sc == 0);
                end else if (step_req) begin
                    if (step_lat == 0) step_done = 1'b1;
                    else sc = step_lat;
                end
                if (stray_vld && step_req && vc == 0) cs_vld = 1'b1;
                if (stray_sd && vc > 0 && !cs_en) step_done = 1'b1;
                if (cs_en) begin
                    sw_q.push_back(cs_swap);
                    idx_q.push_back(int'(bit_idx));
                    held = cs_swap; waiting = 1'b1;
                end else if (waiting) begin
                    if (cs_swap !== held) stab_tot++;
                    if (cs_vld) waiting = 1'b0;
                end
                if (done) done_tot++;
                if (busy) busy_tot++;
            end
        end
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_q(input string nm);
        int first;
        first = -1;
        total++;
        if (got_sw.size() != exp_sw.size() || got_idx.size() != exp_idx.size()) begin
            bad++;
            $display("FAIL %s: got %0d swaps expected %0d", nm, got_sw.size(), exp_sw.size());
        end else begin
            for (int i = 0; i < exp_sw.size(); i++)
                if (first < 0 && (got_sw[i] != exp_sw[i] || got_idx[i] != exp_idx[i]))
                    first = i;
            if (first >= 0) begin
                bad++;
                $display("FAIL %s: swap #%0d got swap=%0d idx=%0d expected swap=%0d idx=%0d",
                         nm, first, got_sw[first], got_idx[first],
                         exp_sw[first], exp_idx[first]);
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] k, input int lat,
                          input bit sv, input bit ssd, input bit restart);
        int base_sw, base_done, base_busy, base_stab, n, budget;
        base_sw = sw_q.size(); base_done = done_tot;
        base_busy = busy_tot; base_stab = stab_tot;
        step_lat = lat; stray_vld = sv; stray_sd = ssd;
        budget = NB * 16 + 100;
        @(posedge clk); #2; scalar = k; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        if (restart) begin
            repeat (6) @(posedge clk);
            #2; scalar = W'(1); start = 1'b1;
            @(posedge clk); #2; start = 1'b0;
        end
        n = 0;
        while (done_tot == base_done && n < budget) begin
            @(posedge clk); #2; n++;
        end
        if (n >= budget) chk("done timeout", 0, 1);
        repeat (3) @(posedge clk);
        #2;
        stray_vld = 1'b0; stray_sd = 1'b0;
        got_sw.delete(); got_idx.delete();
        for (int i = base_sw; i < sw_q.size(); i++) begin
            got_sw.push_back(sw_q[i]);
            got_idx.push_back(idx_q[i]);
        end
        got_done = done_tot - base_done;
        got_busy = busy_tot - base_busy;
        got_stab = stab_tot - base_stab;
    endtask

    // Ladder rule: swap_t = k[t] ^ k[t+1] from the top, then a final swap of k[0]
    task automatic model(input logic [W-1:0] k_raw, input int lat, output int cyc);
        logic [W-1:0] k;
        bit prev;
        k = k_raw;
`ifdef X25519_CLAMP_EN
        k[2:0] = 3'b000; k[255] = 1'b0; k[254] = 1'b1;
`endif
        exp_sw.delete(); exp_idx.delete();
        prev = 1'b0;
        for (int t = NB - 1; t >= 0; t--) begin
            exp_sw.push_back(k[t] ^ prev);
            exp_idx.push_back(t);
            prev = k[t];
        end
        exp_sw.push_back(prev);
        exp_idx.push_back(0);
        cyc = NB * (1 + CSWAP_LAT + lat + 1) + (1 + CSWAP_LAT) + 1;
    endtask

    task automatic check_op(input string nm, input int cyc);
        chk_q({nm, " swaps"});
        chk({nm, " done pulses"}, got_done, 1);
        chk({nm, " busy cycles"}, got_busy, cyc);
        chk({nm, " cs_swap stable"}, got_stab, 0);
    endtask

    typedef struct {
        logic [3:0] k;
        int         lat;
        bit         sv;
        bit         ssd;
        bit         restart;
        logic [4:0] sw;
        int         cyc;
    } vec_t;

    initial begin : main
        vec_t vecs[6];
        int   cyc, n, cyc_zero, cyc_ones;
        logic [W-1:0] k;

        rst = 1'b1; start = 1'b0; scalar = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset cs_en", cs_en, 0);
        chk("reset cs_swap", cs_swap, 0);
        chk("reset step_req", step_req, 0);
        chk("reset bit_idx", bit_idx, 0);
        rst = 1'b0;

`ifndef X25519_CLAMP_EN
        vecs[0] = '{4'b1011, 2, 1'b0, 1'b0, 1'b0, 5'b11101, 33};
        vecs[1] = '{4'b0000, 2, 1'b0, 1'b0, 1'b0, 5'b00000, 33};
        vecs[2] = '{4'b1111, 2, 1'b0, 1'b0, 1'b0, 5'b10001, 33};
        vecs[3] = '{4'b0001, 0, 1'b0, 1'b0, 1'b0, 5'b00011, 25};
        vecs[4] = '{4'b0110, 3, 1'b1, 1'b1, 1'b0, 5'b01010, 37};
        vecs[5] = '{4'b1011, 2, 1'b0, 1'b0, 1'b1, 5'b11101, 33};
        cyc_zero = 0; cyc_ones = 0;
        for (int v = 0; v < 6; v++) begin
            run_op(W'(vecs[v].k), vecs[v].lat, vecs[v].sv, vecs[v].ssd, vecs[v].restart);
            exp_sw.delete(); exp_idx.delete();
            for (int i = 4; i >= 0; i--) exp_sw.push_back(vecs[v].sw[i]);
            for (int i = 0; i < NB; i++) exp_idx.push_back(NB - 1 - i);
            exp_idx.push_back(0);
            check_op($sformatf("vec%0d", v), vecs[v].cyc);
            chk($sformatf("vec%0d cs_en pulses", v), got_sw.size(), 5);
            if (v == 1) cyc_zero = got_busy;
            if (v == 2) cyc_ones = got_busy;
        end
        chk("constant time 0000 vs 1111", cyc_zero, cyc_ones);

        // reset during the step of bit 2, then a clean rerun
        step_lat = 2;
        @(posedge clk); #2; scalar = W'(4'b1011); start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        n = 0;
        while (!(bit_idx == 2 && step_req) && n < 200) begin
            @(posedge clk); #2; n++;
        end
        chk("reach step of bit 2", int'(n < 200), 1);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("midrst busy", busy, 0);
        chk("midrst step_req", step_req, 0);
        chk("midrst cs_en", cs_en, 0);
        chk("midrst bit_idx", bit_idx, 0);
        rst = 1'b0;
        run_op(W'(4'b1011), 2, 1'b0, 1'b0, 1'b0);
        model(W'(4'b1011), 2, cyc);
        check_op("after reset", cyc);

        for (int r = 0; r < 20; r++) begin
            int lat;
            for (int c = 0; c < W / 32; c++) k[c*32 +: 32] = $urandom;
            lat = $urandom_range(0, 3);
            run_op(k, lat, 1'($urandom), 1'($urandom), 1'b0);
            model(k, lat, cyc);
            check_op($sformatf("rand%0d", r), cyc);
        end
`else
        run_op('1, 1, 1'b0, 1'b0, 1'b0);
        model('1, 1, cyc);
        check_op("clamp ones", cyc);
        chk("clamp first swap", got_sw.size() > 0 ? int'(got_sw[0]) : -1, 1);
        chk("clamp final swap", got_sw.size() > 0 ? int'(got_sw[got_sw.size()-1]) : -1, 0);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < W / 32; c++) k[c*32 +: 32] = $urandom;
            run_op(k, 1, 1'b1, 1'b1, 1'b0);
            model(k, 1, cyc);
            check_op($sformatf("clamp rand%0d", r), cyc);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
